reaction_timer_ctrl: RTL and testbench
======================================

// Module: reaction_timer_ctrl
// PURPOSE
//  Game sequencer for the F1 reaction-timer datapath. Starts a run by pulsing the light-sequence FSM,
//  waits for the random-delay lights-out event, then counts milliseconds until the player reacts.
//  Reports the result, false starts and timeouts, and optionally tracks the best time.
//  Sits between the KEY inputs, the light-sequence FSM/delay chain and the bin2bcd/7-seg display path.
// PARAMETERS
//  CNT_W   14    width of all millisecond values
//  MAX_MS  9999  saturation/timeout value in ms; must fit 4 BCD digits and CNT_W bits
// PORTS
//  CLOCK_50     in   1      system clock, 50 MHz; all logic on rising edge
//  reset        in   1      synchronous, active-high reset
//  tick_ms      in   1      1-cycle strobe, once per ms
//  start_lvl    in   1      start button, active-high level, already synchronised
//  react_lvl    in   1      reaction button, active-high level, already synchronised
//  lights_out   in   1      1-cycle pulse from delay block: lights extinguished
//  seq_start    out  1      1-cycle pulse: start light sequence + LFSR/delay
//  busy         out  1      high in ARM or MEASURE
//  rt_ms        out  CNT_W  running/final reaction time in ms
//  rt_valid     out  1      high in DONE: rt_ms holds a valid result
//  false_start  out  1      high in FALSE state
//  timed_out    out  1      high in DONE when rt_ms saturated at MAX_MS
//  best_ms      out  CNT_W  best valid time (BEST_TIME_EN only, else tied to 0)
//  new_best     out  1      1-cycle pulse when best_ms updated (BEST_TIME_EN only, else 0)
// BEHAVIOUR
//  - Edge detect: start_ev = start_lvl & ~start_q; react_ev likewise; *_q regs reset to 1 (held button
//    at reset does not fire).
//  - All outputs registered; state change and outputs update on the edge where the event is sampled.
//  - States: IDLE, ARM, MEASURE, DONE, FALSE.
//    IDLE: start_ev -> ARM, seq_start=1 for that one cycle, rt_ms cleared to 0.
//    ARM: react_ev -> FALSE (also when react_ev and lights_out in same cycle);
//         lights_out alone -> MEASURE, rt_ms=0. start_ev ignored.
//    MEASURE: react_ev -> DONE, rt_ms frozen (tick_ms in same cycle NOT counted);
//         else tick_ms -> rt_ms+1; when rt_ms+1 reaches MAX_MS -> DONE, timed_out=1. start_ev ignored.
//    DONE/FALSE: outputs held; start_ev -> ARM with seq_start pulse, rt_ms=0, flags cleared.
//  - rt_ms never exceeds MAX_MS; no wrap. lights_out outside ARM is ignored.
//  - Reset (any state): state=IDLE, rt_ms=0, all flags/pulses 0, best_ms=MAX_MS, start_q=react_q=1.
// CONFIGURATION
//  BEST_TIME_EN defined: on MEASURE->DONE by react (not timeout) with rt_ms_final < best_ms,
//    best_ms <= rt_ms_final and new_best pulses 1 cycle (same edge as DONE entry). Ties do not update.
//    best_ms survives restarts; cleared only by reset.
//  BEST_TIME_EN undefined: no best register; best_ms=0, new_best=0 constant.
// STRUCTURE
//  - Package rt_pkg: state enum (IDLE, ARM, MEASURE, DONE, FALSE), CNT_W/MAX_MS defaults.
//  - Sub-module ms_counter: clear/enable saturating counter (clr, en, sat flag), used for rt_ms.
//  - FSM, edge detectors and best-time register in top of this block.
// TESTING
//  1. reset, start pulse, lights_out, 237 tick_ms, react -> rt_ms=237, rt_valid=1, seq_start pulsed once.
//  2. react during ARM (before lights_out) -> FALSE, false_start=1, rt_ms=0; then start -> ARM, flag cleared.
//  3. no react for 9999 ticks after lights_out -> DONE, rt_ms=9999, timed_out=1, best_ms unchanged.
//  4. react and tick_ms same cycle at count 100 -> rt_ms=100; react+lights_out same cycle -> FALSE.
//  5. BEST_TIME_EN: runs 300, 250, 250, 400 -> best_ms 300,250,250,250; new_best pulses on runs 1,2 only.
//  6. reset asserted mid-MEASURE at rt_ms=50 with start_lvl held -> IDLE, rt_ms=0, no start_ev after release
//     of reset until start_lvl goes low then high.

Source files
------------

// File: rtl/rt_pkg.sv
// Shared types and default sizing for the reaction-timer game sequencer.
package rt_pkg;

   localparam int unsigned DefCntW  = 14;
   localparam int unsigned DefMaxMs = 9999;

   typedef enum logic [2:0] {
      StIdle,
      StArm,
      StMeasure,
      StDone,
      StFalse
   } rt_state_e;

endpackage

// File: rtl/reaction_timer_ctrl_if.sv
// Button/light/display signal bundle between the game sequencer and its surroundings.
interface reaction_timer_ctrl_if #(
   parameter int unsigned CNT_W = rt_pkg::DefCntW
);

   logic             tick_ms;
   logic             start_lvl;
   logic             react_lvl;
   logic             lights_out;
   logic             seq_start;
   logic             busy;
   logic [CNT_W-1:0] rt_ms;
   logic             rt_valid;
   logic             false_start;
   logic             timed_out;
   logic [CNT_W-1:0] best_ms;
   logic             new_best;

   modport slave (
      input  tick_ms, start_lvl, react_lvl, lights_out,
      output seq_start, busy, rt_ms, rt_valid, false_start, timed_out, best_ms, new_best
   );

   modport master (
      output tick_ms, start_lvl, react_lvl, lights_out,
      input  seq_start, busy, rt_ms, rt_valid, false_start, timed_out, best_ms, new_best
   );

endinterface

// File: rtl/ms_counter.sv
// Clear/enable millisecond counter that saturates at MAX_MS instead of wrapping.
module ms_counter #(
   parameter int unsigned CNT_W  = 14,
   parameter int unsigned MAX_MS = 9999
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             sat_o,
   output logic             last_o
);

   localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_MS);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != MaxCnt)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign sat_o  = (cnt_q == MaxCnt);
   // One more increment lands exactly on the saturation value.
   assign last_o = (cnt_q == (MaxCnt - 1'b1));

endmodule

// File: rtl/reaction_timer_ctrl.sv
// F1 reaction-timer game sequencer: arm, wait for lights-out, measure ms until reaction.
// Optional best-time tracking is built when BEST_TIME_EN is defined.
module reaction_timer_ctrl
   import rt_pkg::*;
#(
   parameter int unsigned CNT_W  = DefCntW,
   parameter int unsigned MAX_MS = DefMaxMs
) (
   input  logic                  CLOCK_50,
   input  logic                  reset,
   reaction_timer_ctrl_if.slave  bus
);

   rt_state_e        state_q;
   logic             start_q, react_q;
   logic             start_ev, react_ev;
   logic             seq_start_q, busy_q, rt_valid_q, false_start_q, timed_out_q;
   logic             cnt_clr, cnt_en, cnt_sat, cnt_last;
   logic [CNT_W-1:0] cnt;

   assign start_ev = bus.start_lvl & ~start_q;
   assign react_ev = bus.react_lvl & ~react_q;

   always_comb begin
      cnt_clr = 1'b0;
      cnt_en  = 1'b0;
      case (state_q)
         StIdle, StDone, StFalse: cnt_clr = start_ev;
         StArm:                   cnt_clr = 1'b1;
         // A tick in the same cycle as the reaction is not counted.
         StMeasure:               cnt_en  = bus.tick_ms & ~react_ev;
         default:                 cnt_clr = 1'b1;
      endcase
   end

   ms_counter #(
      .CNT_W  (CNT_W),
      .MAX_MS (MAX_MS)
   ) u_ms_counter (
      .clk_i  (CLOCK_50),
      .rst_i  (reset),
      .clr_i  (cnt_clr),
      .en_i   (cnt_en),
      .cnt_o  (cnt),
      .sat_o  (cnt_sat),
      .last_o (cnt_last)
   );

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q       <= StIdle;
         start_q       <= 1'b1;
         react_q       <= 1'b1;
         seq_start_q   <= 1'b0;
         busy_q        <= 1'b0;
         rt_valid_q    <= 1'b0;
         false_start_q <= 1'b0;
         timed_out_q   <= 1'b0;
      end else begin
         start_q     <= bus.start_lvl;
         react_q     <= bus.react_lvl;
         seq_start_q <= 1'b0;
         case (state_q)
            StIdle, StDone, StFalse: begin
               if (start_ev) begin
                  state_q       <= StArm;
                  seq_start_q   <= 1'b1;
                  busy_q        <= 1'b1;
                  rt_valid_q    <= 1'b0;
                  false_start_q <= 1'b0;
                  timed_out_q   <= 1'b0;
               end
            end
            StArm: begin
               if (react_ev) begin
                  state_q       <= StFalse;
                  busy_q        <= 1'b0;
                  false_start_q <= 1'b1;
               end else if (bus.lights_out) begin
                  state_q <= StMeasure;
               end
            end
            StMeasure: begin
               if (react_ev) begin
                  state_q    <= StDone;
                  busy_q     <= 1'b0;
                  rt_valid_q <= 1'b1;
               end else if (bus.tick_ms && (cnt_last || cnt_sat)) begin
                  state_q     <= StDone;
                  busy_q      <= 1'b0;
                  rt_valid_q  <= 1'b1;
                  timed_out_q <= 1'b1;
               end
            end
            default: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.seq_start   = seq_start_q;
   assign bus.busy        = busy_q;
   assign bus.rt_ms       = cnt;
   assign bus.rt_valid    = rt_valid_q;
   assign bus.false_start = false_start_q;
   assign bus.timed_out   = timed_out_q;

`ifdef BEST_TIME_EN
   localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_MS);

   logic [CNT_W-1:0] best_q;
   logic             new_best_q;

   // Only a reaction can set a record; ties keep the earlier one.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         best_q     <= MaxCnt;
         new_best_q <= 1'b0;
      end else begin
         new_best_q <= 1'b0;
         if ((state_q == StMeasure) && react_ev && (cnt < best_q)) begin
            best_q     <= cnt;
            new_best_q <= 1'b1;
         end
      end
   end

   assign bus.best_ms  = best_q;
   assign bus.new_best = new_best_q;
`else
   assign bus.best_ms  = '0;
   assign bus.new_best = 1'b0;
`endif

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Directed self-checking bench for reaction_timer_ctrl; best-time checks follow BEST_TIME_EN.
module tb_reaction_timer_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tot = 0;
   int   n_bad = 0;
   int   seq_cnt = 0;

   reaction_timer_ctrl_if #(.CNT_W(14)) bus ();

   reaction_timer_ctrl #(
      .CNT_W  (14),
      .MAX_MS (9999)
   ) dut (
      .CLOCK_50 (clk),
      .reset    (rst),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.seq_start === 1'b1) seq_cnt <= seq_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", tag, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic press_start();
      bus.start_lvl = 1'b1;
      cyc(1);
      chk("seq_start_pulse", 32'(bus.seq_start), 1);
      chk("busy_on_arm", 32'(bus.busy), 1);
      bus.start_lvl = 1'b0;
      cyc(1);
      chk("seq_start_one_cycle", 32'(bus.seq_start), 0);
   endtask

   task automatic lights();
      bus.lights_out = 1'b1;
      cyc(1);
      bus.lights_out = 1'b0;
   endtask

   task automatic ticks(input int n);
      bus.tick_ms = 1'b1;
      cyc(n);
      bus.tick_ms = 1'b0;
   endtask

   task automatic react();
      bus.react_lvl = 1'b1;
      cyc(1);
      bus.react_lvl = 1'b0;
   endtask

   int run_ms   [4] = '{300, 250, 250, 400};
`ifdef BEST_TIME_EN
   int run_best [4] = '{300, 250, 250, 250};
   int run_nb   [4] = '{1, 1, 0, 0};
   int best_rst     = 9999;
   int best_t3      = 100;
`else
   int run_best [4] = '{0, 0, 0, 0};
   int run_nb   [4] = '{0, 0, 0, 0};
   int best_rst     = 0;
   int best_t3      = 0;
`endif

   initial begin
      int s;
      bus.tick_ms    = 1'b0;
      bus.start_lvl  = 1'b0;
      bus.react_lvl  = 1'b0;
      bus.lights_out = 1'b0;
      cyc(3);
      chk("rst_rt_ms", 32'(bus.rt_ms), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_seq_start", 32'(bus.seq_start), 0);
      chk("rst_rt_valid", 32'(bus.rt_valid), 0);
      chk("rst_false_start", 32'(bus.false_start), 0);
      chk("rst_timed_out", 32'(bus.timed_out), 0);
      chk("rst_best", 32'(bus.best_ms), 32'(best_rst));
      rst = 1'b0;
      cyc(2);

      // Normal run of 237 ms.
      press_start();
      lights();
      chk("t1_rt_zero", 32'(bus.rt_ms), 0);
      ticks(237);
      chk("t1_rt_running", 32'(bus.rt_ms), 237);
      chk("t1_busy_meas", 32'(bus.busy), 1);
      react();
      chk("t1_rt_ms", 32'(bus.rt_ms), 237);
      chk("t1_valid", 32'(bus.rt_valid), 1);
      chk("t1_busy_off", 32'(bus.busy), 0);
      chk("t1_timed_out", 32'(bus.timed_out), 0);
      chk("t1_seq_cnt", 32'(seq_cnt), 1);

      // False start, then restart clears the flag.
      press_start();
      chk("t2_valid_clr", 32'(bus.rt_valid), 0);
      chk("t2_rt_clr", 32'(bus.rt_ms), 0);
      react();
      chk("t2_false", 32'(bus.false_start), 1);
      chk("t2_rt", 32'(bus.rt_ms), 0);
      chk("t2_busy", 32'(bus.busy), 0);
      lights();
      chk("t2_lights_ignored", 32'(bus.false_start), 1);
      press_start();
      chk("t2_false_clr", 32'(bus.false_start), 0);

      // react and lights_out in the same ARM cycle.
      bus.react_lvl  = 1'b1;
      bus.lights_out = 1'b1;
      cyc(1);
      bus.react_lvl  = 1'b0;
      bus.lights_out = 1'b0;
      chk("t4_both_false", 32'(bus.false_start), 1);
      chk("t4_both_busy", 32'(bus.busy), 0);

      // react together with a tick at count 100.
      press_start();
      lights();
      ticks(100);
      bus.react_lvl = 1'b1;
      bus.tick_ms   = 1'b1;
      cyc(1);
      bus.react_lvl = 1'b0;
      bus.tick_ms   = 1'b0;
      chk("t4_rt_100", 32'(bus.rt_ms), 100);
      chk("t4_valid", 32'(bus.rt_valid), 1);
      cyc(2);
      chk("t4_rt_held", 32'(bus.rt_ms), 100);

      // Timeout at MAX_MS.
      press_start();
      lights();
      ticks(9998);
      chk("t3_pre_busy", 32'(bus.busy), 1);
      chk("t3_pre_to", 32'(bus.timed_out), 0);
      ticks(1);
      chk("t3_rt_max", 32'(bus.rt_ms), 9999);
      chk("t3_timed_out", 32'(bus.timed_out), 1);
      chk("t3_valid", 32'(bus.rt_valid), 1);
      chk("t3_busy", 32'(bus.busy), 0);
      ticks(3);
      chk("t3_no_wrap", 32'(bus.rt_ms), 9999);
      chk("t3_best", 32'(bus.best_ms), 32'(best_t3));

      // Best-time sequence from a fresh reset.
      rst = 1'b1;
      cyc(2);
      rst = 1'b0;
      cyc(1);
      chk("t5_best_rst", 32'(bus.best_ms), 32'(best_rst));
      for (int i = 0; i < 4; i++) begin
         press_start();
         lights();
         ticks(run_ms[i]);
         react();
         chk($sformatf("t5_rt_%0d", i), 32'(bus.rt_ms), 32'(run_ms[i]));
         chk($sformatf("t5_nb_%0d", i), 32'(bus.new_best), 32'(run_nb[i]));
         chk($sformatf("t5_best_%0d", i), 32'(bus.best_ms), 32'(run_best[i]));
         cyc(1);
         chk($sformatf("t5_nb_off_%0d", i), 32'(bus.new_best), 0);
      end

      // Reset mid-measure with start held.
      press_start();
      lights();
      ticks(50);
      chk("t6_rt_50", 32'(bus.rt_ms), 50);
      bus.start_lvl = 1'b1;
      rst = 1'b1;
      cyc(2);
      chk("t6_rt_rst", 32'(bus.rt_ms), 0);
      chk("t6_busy_rst", 32'(bus.busy), 0);
      rst = 1'b0;
      s = seq_cnt;
      cyc(3);
      chk("t6_no_start", 32'(bus.busy), 0);
      chk("t6_no_seq", 32'(seq_cnt), 32'(s));
      bus.start_lvl = 1'b0;
      cyc(1);
      press_start();

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
